// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first, WIDTH
// cycles per addition. Reports sum, carry-out and signed overflow on completion.

module full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

module serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shift_a, shift_b, shift_s, shift_s_nxt;
    logic [CW-1:0]    cnt;
    logic             carry, c_msb;
    logic             fa_sum, fa_carry;
    logic             last_bit, accept;

    full_adder u_fa (
        .x  (shift_a[0]),
        .y  (shift_b[0]),
        .ci (carry),
        .s  (fa_sum),
        .co (fa_carry)
    );

    assign last_bit    = (cnt == CW'(WIDTH - 1));
    assign accept      = start && (state != RUN);
    assign shift_s_nxt = {fa_sum, shift_s[WIDTH-1:1]};
    assign busy        = (state == RUN);
    assign done        = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_a <= '0;
            shift_b <= '0;
            shift_s <= '0;
            carry   <= 1'b0;
            c_msb   <= 1'b0;
            cnt     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else if (state == RUN) begin
            shift_a <= shift_a >> 1;
            shift_b <= shift_b >> 1;
            shift_s <= shift_s_nxt;
            carry   <= fa_carry;
            cnt     <= cnt + 1'b1;
            // carry out of bit WIDTH-2 is the carry into the MSB
            if (cnt == CW'(WIDTH - 2)) c_msb <= fa_carry;
            if (last_bit) begin
                sum  <= shift_s_nxt;
                cout <= fa_carry;
                ovf  <= c_msb ^ fa_carry;
            end
        end else if (accept) begin
            shift_a <= a;
            shift_b <= b;
            carry   <= cin;
            cnt     <= '0;
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed vector table, multi-cycle corner sequences
// and randomized operands against an arithmetic reference model.

module tb_serial_adder;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset, start, cin;
    logic [W-1:0] a, b;
    logic         busy, done, cout, ovf;
    logic [W-1:0] sum;

    int n_cmp = 0;
    int n_err = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a, b;
        logic         cin;
        logic [W-1:0] e_sum;
        logic         e_cout, e_ovf;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                         output logic [W-1:0] s, output logic co, output logic ov);
        logic [W:0] full;
        full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        s  = full[W-1:0];
        co = full[W];
        ov = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
    endtask

    // Launch one op, wait for done; returns latency (cycles) and busy-cycle count.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                          output int lat, output int nbusy);
        @(negedge clk);
        start = 1'b1; a = x; b = y; cin = ci;
        @(negedge clk);
        start = 1'b0; a = '0; b = '0; cin = 1'b0;
        lat = 0; nbusy = 0;
        while (!done && lat < 60) begin
            if (busy) nbusy++;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat, nbusy, ndone, gap;
        logic [W-1:0] es;
        logic ec, eo;

        vecs[0] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[5] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};

        reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, lat, nbusy);
            chk($sformatf("v%0d_lat", i), lat, W);
            chk($sformatf("v%0d_busy", i), nbusy, W);
            chk($sformatf("v%0d_sum", i), sum, vecs[i].e_sum);
            chk($sformatf("v%0d_cout", i), cout, vecs[i].e_cout);
            chk($sformatf("v%0d_ovf", i), ovf, vecs[i].e_ovf);
            @(negedge clk);
            chk($sformatf("v%0d_done1", i), done, 0);
            chk($sformatf("v%0d_idle", i), busy, 0);
        end

        // start pulsed while busy must be ignored
        @(negedge clk);
        start = 1'b1; a = 16'h1234; b = 16'h1111; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        ndone = 0; lat = -1;
        for (int c = 1; c <= 30; c++) begin
            if (c == 5) begin start = 1'b1; a = 16'hFFFF; end
            if (c == 6) begin start = 1'b0; a = '0; end
            if (c < 16) chk("ign_sum_hold", sum, 16'h5556);
            if (done) begin ndone++; if (lat < 0) lat = c - 1; end
            @(negedge clk);
        end
        chk("ign_sum", sum, 16'h2345);
        chk("ign_ndone", ndone, 1);
        chk("ign_lat", lat, W);

        // reset mid-run
        start = 1'b1; a = 16'hAAAA; b = 16'h5555;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        chk("mid_busy_pre", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_busy", busy, 0);
        chk("mid_done", done, 0);
        chk("mid_sum", sum, 0);
        chk("mid_cout", cout, 0);
        reset = 1'b0;
        ndone = 0;
        repeat (30) begin @(negedge clk); if (done || busy) ndone++; end
        chk("mid_nodone", ndone, 0);

        // reset and start together: reset wins
        reset = 1'b1; start = 1'b1; a = 16'h0001; b = 16'h0001;
        @(negedge clk);
        chk("rs_busy", busy, 0);
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rs_idle", busy, 0);

        // back-to-back with start held through DONE
        start = 1'b1; a = 16'h00FF; b = 16'h0001; cin = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!done && lat < 60) begin @(negedge clk); lat++; end
        chk("b2b_done1", done, 1);
        chk("b2b_sum1", sum, 16'h0100);
        chk("b2b_cout1", cout, 0);
        a = 16'h8000; b = 16'h8000;
        @(negedge clk);
        start = 1'b0; a = '0; b = '0;
        chk("b2b_nobubble", busy, 1);
        gap = 1;
        while (!done && gap < 60) begin @(negedge clk); gap++; end
        chk("b2b_gap", gap, W + 1);
        chk("b2b_sum2", sum, 16'h0000);
        chk("b2b_cout2", cout, 1);
        chk("b2b_ovf2", ovf, 1);
        @(negedge clk);

        // randomized operands against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            logic rc;
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            if (i == 0) begin ra = 16'h8000; rb = 16'h8000; end
            model(ra, rb, rc, es, ec, eo);
            run_op(ra, rb, rc, lat, nbusy);
            chk("rnd_lat", lat, W);
            chk("rnd_sum", sum, es);
            chk("rnd_cout", cout, ec);
            chk("rnd_ovf", ovf, eo);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
